reg_wb_bank: RTL and testbench

REG_WB_BANK -- requirements
Module: reg_wb_bank

---
 rtl/reg_wb_bank.sv | 128 ++++++++++++
 tb/tb_reg_wb_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_bank.sv
// reg_wb_bank: 32-entry register array fed through an in-order write-back FIFO.
//
// Write requests ({wb_addr, wb_data}) are accepted into a DEPTH-entry FIFO
// whenever it has room. One entry drains into the register array per clock,
// unless hold is high. Accepted data therefore reaches reg_q no earlier than
// one cycle after acceptance.
//
// Parameters:
//   WIDTH  register data width
//   DEPTH  FIFO entries; power of two, 2..16
//
// Ports:
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   wb_valid  write request present
//   wb_ready  FIFO can accept a request (registered count only, no valid->ready path)
//   wb_addr   destination register index 0..31
//   wb_data   write data
//   hold      freezes draining while high; pushes continue until full
//   reg_q     all 32 registers flattened, register i at [WIDTH*i +: WIDTH]
//   pending   bit i set while any buffered entry targets register i
//   count     number of buffered entries
//
// Optional feature: define REG_WB_BANK_ZERO_R0_EN to make register 0 a
// hard-wired zero. Requests to address 0 are then accepted and dropped.

module reg_wb_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [4:0]               wb_addr,
    input  logic [WIDTH-1:0]         wb_data,
    input  logic                     hold,
    output logic [32*WIDTH-1:0]      reg_q,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] regs      [32];
    logic [4:0]       fifo_addr [DEPTH];
    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             buf_en;
    logic             push;
    logic             pop;

`ifdef REG_WB_BANK_ZERO_R0_EN
    // Writes to the zero register are consumed by the handshake but never stored.
    assign buf_en = (wb_addr != 5'd0);
`else
    assign buf_en = 1'b1;
`endif

    assign wb_ready = !rst && (count < DEPTH_C);
    assign push     = wb_valid && wb_ready && buf_en;
    assign pop      = (count != '0) && !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                regs[fifo_addr[rd_ptr]] <= fifo_data[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read while count marks it valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wb_addr;
            fifo_data[wr_ptr] <= wb_data;
        end
    end

    // An entry is live when its distance from the read pointer (mod DEPTH)
    // is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        pending = '0;
        offset  = '0;
        for (int j = 0; j < DEPTH; j++) begin
            offset = PTR_W'(j) - rd_ptr;
            if ({1'b0, offset} < count) begin
                pending[fifo_addr[j]] = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_regq
            if (g == 0) begin : g_r0
`ifdef REG_WB_BANK_ZERO_R0_EN
                assign reg_q[WIDTH-1:0] = '0;
`else
                assign reg_q[WIDTH-1:0] = regs[0];
`endif
            end else begin : g_rn
                assign reg_q[WIDTH*g +: WIDTH] = regs[g];
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_wb_bank.sv
// Bench for reg_wb_bank (WIDTH 32, DEPTH 4). The driver issues directed
// requests with hand-computed checks; a negedge monitor keeps a reference
// FIFO/register model, pushing expected entries on acceptance and popping
// them when the DUT drains, then compares all outputs every cycle.

module tb_reg_wb_bank;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic              wb_ready;
    logic [4:0]        wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              hold;
    logic [32*WIDTH-1:0] reg_q;
    logic [31:0]       pending;
    logic [2:0]        count;

    int vectors    = 0;
    int miscompares = 0;

    reg_wb_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .hold     (hold),
        .reg_q    (reg_q),
        .pending  (pending),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        sb_q [$];
    logic [31:0] m_regs [32];
    int          m_cnt;
    logic [31:0]         m_pend;
    logic [32*WIDTH-1:0] m_flat;
    ent_t                m_head;
    logic                m_push;
    logic                m_pop;
    int                  first_bad;

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt = 0;
        end
        m_pend = '0;
        foreach (sb_q[k]) m_pend[sb_q[k].a] = 1'b1;
        for (int i = 0; i < 32; i++) m_flat[32*i +: 32] = m_regs[i];

        chk("mon_count", 32'(count), 32'(m_cnt));
        chk("mon_ready", 32'(wb_ready), 32'(!rst && m_cnt < DEPTH));
        chk("mon_pending", pending, m_pend);
        vectors++;
        if (reg_q !== m_flat) begin
            miscompares++;
            first_bad = -1;
            for (int i = 31; i >= 0; i--)
                if (reg_q[32*i +: 32] !== m_flat[32*i +: 32]) first_bad = i;
            $display("FAIL mon_reg_q[%0d]: got %h expected %h at %0t", first_bad,
                     reg_q[32*first_bad +: 32], m_flat[32*first_bad +: 32], $time);
        end

        // predict the next rising edge
        if (!rst) begin
            m_pop  = (m_cnt > 0) && !hold;
            m_push = wb_valid && (m_cnt < DEPTH);
`ifdef REG_WB_BANK_ZERO_R0_EN
            if (wb_addr == 5'd0) m_push = 1'b0;
`endif
            if (m_pop) begin
                m_head = sb_q.pop_front();
                m_regs[m_head.a] = m_head.d;
                m_cnt--;
            end
            if (m_push) begin
                sb_q.push_back('{a: wb_addr, d: wb_data});
                m_cnt++;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        int n;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        n = 0;
        while (!wb_ready && n < 50) begin
            step();
            n++;
        end
        chk("push_ready", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; hold = 1'b0;
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(wb_ready), 32'd0);
        chk("rst_pending", pending, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(wb_ready), 32'd1);

        // single write: visible one edge after acceptance
        push(5'd5, 32'hDEADBEEF);
        chk("w5_count_after_accept", 32'(count), 32'd1);
        chk("w5_pending_set", 32'(pending[5]), 32'd1);
        chk("w5_not_yet", reg_q[5*32 +: 32], 32'd0);
        step();
        chk("w5_landed", reg_q[5*32 +: 32], 32'hDEADBEEF);
        chk("w5_pending_clr", 32'(pending[5]), 32'd0);
        chk("w5_count_zero", 32'(count), 32'd0);

        // fill under hold, fifth request refused
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) push(5'(k), 32'h10 + 32'(k));
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        repeat (3) step();
        chk("full_ready", 32'(wb_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_pending", pending, 32'h0000_001E);
        chk("hold_no_write", reg_q[1*32 +: 32], 32'd0);
        wb_valid = 1'b0;
        hold = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("drain_count", 32'(count), 32'(4 - k));
            chk("drain_value", reg_q[k*32 +: 32], 32'h10 + 32'(k));
        end
        chk("reg9_untouched", reg_q[9*32 +: 32], 32'd0);

        // same register twice back-to-back
        push(5'd7, 32'h1);
        push(5'd7, 32'h2);
        chk("r7_mid_value", reg_q[7*32 +: 32], 32'h1);
        chk("r7_mid_pending", 32'(pending[7]), 32'd1);
        step();
        chk("r7_final", reg_q[7*32 +: 32], 32'h2);
        chk("r7_pending_clr", 32'(pending[7]), 32'd0);

        // 20 continuous pushes, pointer wrap
        for (int i = 0; i < 20; i++) begin
            push(5'(10 + i % 5), 32'd100 + 32'(i));
            chk("stream_count", 32'(count), 32'd1);
        end
        step();
        chk("stream_empty", 32'(count), 32'd0);
        for (int k = 0; k < 5; k++)
            chk("stream_last", reg_q[(10 + k)*32 +: 32], 32'd115 + 32'(k));

        // reset with entries buffered
        hold = 1'b1;
        push(5'd20, 32'hA0);
        push(5'd21, 32'hA1);
        push(5'd22, 32'hA2);
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_pending", pending, 32'd0);
        chk("mid_rst_ready", 32'(wb_ready), 32'd0);
        chk("mid_rst_r5", reg_q[5*32 +: 32], 32'd0);
        step();
        hold = 1'b0;
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("post_rst_r20", reg_q[20*32 +: 32], 32'd0);
        chk("post_rst_r22", reg_q[22*32 +: 32], 32'd0);
        chk("post_rst_cnt", 32'(count), 32'd0);

        // register 0
        push(5'd0, 32'hFFFFFFFF);
`ifdef REG_WB_BANK_ZERO_R0_EN
        chk("r0_count", 32'(count), 32'd0);
        step();
        chk("r0_value", reg_q[31:0], 32'd0);
`else
        chk("r0_count", 32'(count), 32'd1);
        step();
        chk("r0_value", reg_q[31:0], 32'hFFFFFFFF);
`endif
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
